sprite_anim_engine: RTL and testbench

Positioned, scaled, multi-frame sprite fetch engine for the VGA pipeline. It replaces full-screen stretch drawing with an animation sequencer and a hit-test/address stage. For each pixel it computes the sprite ROM address for the current animation frame, position, scale and facing, then returns a registered palette index and an opaque flag. The compositor uses these to layer sprites over the background.

---
 rtl/sprite_anim_engine.sv | 151 +++++++++++++++
 tb/tb_sprite_anim_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_engine.sv
// Sprite fetch engine: animation sequencer, shadowed position/flip, hit test and ROM address pipeline.
// Define ANIM_LOOP_EN to wrap the animation forever instead of stopping in DONE.
module sprite_anim_engine #(
  parameter int SPRITE_W        = 50,
  parameter int SPRITE_H        = 64,
  parameter int NUM_FRAMES      = 4,
  parameter int SCALE_LOG2      = 0,
  parameter int FRAME_HOLD      = 6,
  parameter int IDX_W           = 3,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ADDR_W          = 12,
  parameter int FIDX_W          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_tick,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip,
  input  logic              anim_start,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pixel_idx,
  output logic              pixel_on,
  output logic [FIDX_W-1:0] frame_idx,
  output logic              busy,
  output logic              anim_done
);

  localparam int          HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int          FRAME_SZ = SPRITE_W * SPRITE_H;
  localparam logic [10:0] EXT_W    = 11'(SPRITE_W << SCALE_LOG2);
  localparam logic [10:0] EXT_H    = 11'(SPRITE_H << SCALE_LOG2);
  localparam int          STAGES   = 1;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [FIDX_W-1:0]   frame_q, frame_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;

  logic [9:0]          pos_x_q, pos_y_q;
  logic                flip_q;

  logic [ADDR_W-1:0]   rom_addr_q;
  logic [STAGES:0]     vld_pipe_q;
  logic [IDX_W-1:0]    pix_idx_q;
  logic                pix_on_q;

  // ---------------------------------------------------------------------------
  // Animation sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    // A restart swallows any tick arriving in the same cycle.
    if (anim_start) begin
      state_d = S_PLAY;
      frame_d = '0;
      hold_d  = '0;
    end else if (state_q == S_PLAY && frame_tick) begin
      if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
        hold_d = '0;
        if (frame_q == FIDX_W'(NUM_FRAMES - 1)) begin
`ifdef ANIM_LOOP_EN
          frame_d = '0;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          frame_d = frame_q + FIDX_W'(1);
        end
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hit test and texel address (11-bit so pos + extent never wraps)
  // ---------------------------------------------------------------------------
  logic [10:0]       px, py, sx, sy, dx, dy, tx, ty, txf;
  logic              hit;
  logic [ADDR_W-1:0] addr_c;

  always_comb begin
    px     = {1'b0, DrawX};
    py     = {1'b0, DrawY};
    sx     = {1'b0, pos_x_q};
    sy     = {1'b0, pos_y_q};
    hit    = (px >= sx) && (px < sx + EXT_W) && (py >= sy) && (py < sy + EXT_H);
    dx     = px - sx;
    dy     = py - sy;
    tx     = dx >> SCALE_LOG2;
    ty     = dy >> SCALE_LOG2;
    txf    = flip_q ? (11'(SPRITE_W - 1) - tx) : tx;
    addr_c = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ)
           + ADDR_W'(ty) * ADDR_W'(SPRITE_W)
           + ADDR_W'(txf);
  end

  // ---------------------------------------------------------------------------
  // State, shadows and pixel pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      flip_q     <= 1'b0;
      rom_addr_q <= '0;
      vld_pipe_q <= '0;
      pix_idx_q  <= '0;
      pix_on_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      // Shadows only move during vblank so a frame never tears.
      if (frame_tick) begin
        pos_x_q <= pos_x;
        pos_y_q <= pos_y;
        flip_q  <= flip;
      end
      if (hit) rom_addr_q <= addr_c;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], hit & blank};
      // vld_pipe_q[STAGES] lines up with rom_q for the same pixel.
      pix_idx_q  <= rom_q;
      pix_on_q   <= vld_pipe_q[STAGES] && (rom_q != IDX_W'(TRANSPARENT_IDX));
    end
  end

  assign rom_address = rom_addr_q;
  assign pixel_idx   = pix_idx_q;
  assign pixel_on    = pix_on_q;
  assign frame_idx   = frame_q;
  assign busy        = (state_q == S_PLAY);
  assign anim_done   = done_q;

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Bench for sprite_anim_engine: scale-1x and scale-2x instances share stimulus, expectations come from a
// behavioural model pushed into per-pixel scoreboard queues.
module tb_sprite_anim_engine;

  localparam int SW = 50, SH = 64, NF = 4, FH = 6, IW = 3, AW = 14;

  logic          vga_clk = 1'b0;
  logic          Reset;
  logic [9:0]    DrawX, DrawY, pos_x, pos_y;
  logic          blank, frame_tick, flip, anim_start;
  logic [AW-1:0] rom_address0, rom_address1;
  logic [IW-1:0] rom_q0 = '0, rom_q1 = '0;
  logic [IW-1:0] pixel_idx0, pixel_idx1;
  logic          pixel_on0, pixel_on1;
  logic [1:0]    frame_idx0, frame_idx1;
  logic          busy0, busy1, anim_done0, anim_done1;

  always #5 vga_clk = ~vga_clk;

  sprite_anim_engine #(.SPRITE_W(SW), .SPRITE_H(SH), .NUM_FRAMES(NF), .SCALE_LOG2(0), .FRAME_HOLD(FH),
                       .IDX_W(IW), .TRANSPARENT_IDX(0), .ADDR_W(AW)) dut0 (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .flip(flip), .anim_start(anim_start),
    .rom_address(rom_address0), .rom_q(rom_q0), .pixel_idx(pixel_idx0), .pixel_on(pixel_on0),
    .frame_idx(frame_idx0), .busy(busy0), .anim_done(anim_done0));

  sprite_anim_engine #(.SPRITE_W(SW), .SPRITE_H(SH), .NUM_FRAMES(NF), .SCALE_LOG2(1), .FRAME_HOLD(FH),
                       .IDX_W(IW), .TRANSPARENT_IDX(0), .ADDR_W(AW)) dut1 (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .flip(flip), .anim_start(anim_start),
    .rom_address(rom_address1), .rom_q(rom_q1), .pixel_idx(pixel_idx1), .pixel_on(pixel_on1),
    .frame_idx(frame_idx1), .busy(busy1), .anim_done(anim_done1));

  // ROM contents: low three address bits, so word 0 (and every 8th word) is transparent.
  function automatic logic [IW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[2:0];
  endfunction

  always @(posedge vga_clk) begin
    rom_q0 <= rom_fn(rom_address0);
    rom_q1 <= rom_fn(rom_address1);
  end

  typedef struct packed {logic on; logic [IW-1:0] idx;} pix_t;

  int   checks = 0, errors = 0;
  int   m_px, m_py, m_fr, m_hold, m_st, m_a0, m_a1;
  bit   m_fl, m_done;
  int   qa0[$], qa1[$];
  pix_t qp0[$], qp1[$];
  int   exp_a0, exp_a1;
  bit   due;
  pix_t exp_p0, exp_p1;

  function automatic int model_addr(input int x, y, sc, px, py, input bit fl, input int fr);
    int ew, eh, tx, ty;
    ew = SW << sc;
    eh = SH << sc;
    if (x < px || x >= px + ew || y < py || y >= py + eh) return -1;
    tx = (x - px) >> sc;
    ty = (y - py) >> sc;
    if (fl) tx = SW - 1 - tx;
    return fr * SW * SH + ty * SW + tx;
  endfunction

  task automatic model_reset();
    m_px = 0; m_py = 0; m_fl = 0; m_fr = 0; m_hold = 0; m_st = 0; m_done = 0;
    m_a0 = 0; m_a1 = 0;
    qa0.delete(); qa1.delete(); qp0.delete(); qp1.delete();
    due = 0;
  endtask

  // Drive one pixel clock; push its expectations; pop the address due now and any pixel due now.
  task automatic cycle(input int x, y, input bit blk, tk, st);
    int   a;
    pix_t p;
    @(negedge vga_clk);
    DrawX = 10'(x); DrawY = 10'(y); blank = blk; frame_tick = tk; anim_start = st;
    a = model_addr(x, y, 0, m_px, m_py, m_fl, m_fr);
    if (a >= 0) m_a0 = a;
    qa0.push_back(m_a0);
    p.idx = rom_fn(AW'(m_a0)); p.on = (a >= 0) && blk && (p.idx != '0);
    qp0.push_back(p);
    a = model_addr(x, y, 1, m_px, m_py, m_fl, m_fr);
    if (a >= 0) m_a1 = a;
    qa1.push_back(m_a1);
    p.idx = rom_fn(AW'(m_a1)); p.on = (a >= 0) && blk && (p.idx != '0);
    qp1.push_back(p);
    m_done = 0;
    if (st) begin
      m_st = 1; m_fr = 0; m_hold = 0;
    end else if (tk && m_st == 1) begin
      m_hold++;
      if (m_hold == FH) begin
        m_hold = 0;
        if (m_fr == NF - 1) begin
`ifdef ANIM_LOOP_EN
          m_fr = 0;
`else
          m_st = 2; m_done = 1;
`endif
        end else m_fr++;
      end
    end
    if (tk) begin m_px = int'(pos_x); m_py = int'(pos_y); m_fl = flip; end
    @(posedge vga_clk); #1;
    exp_a0 = qa0.pop_front();
    exp_a1 = qa1.pop_front();
    due = 0;
    if (qp0.size() == 3) begin
      due = 1; exp_p0 = qp0.pop_front(); exp_p1 = qp1.pop_front();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    DrawX = '0; DrawY = '0; blank = 0; frame_tick = 0; anim_start = 0;
    pos_x = '0; pos_y = '0; flip = 0;
    #1;
    checks++;
    if ({rom_address0, pixel_idx0, pixel_on0, frame_idx0, busy0, anim_done0} !== '0) begin
      errors++; $display("FAIL reset_async got %h/%h/%b/%h/%b/%b want all 0",
        rom_address0, pixel_idx0, pixel_on0, frame_idx0, busy0, anim_done0);
    end
    repeat (2) @(posedge vga_clk);
    #1;
    checks++;
    if ({rom_address1, pixel_idx1, pixel_on1, frame_idx1, busy1, anim_done1} !== '0) begin
      errors++; $display("FAIL reset_held got %h/%h/%b/%h/%b/%b want all 0",
        rom_address1, pixel_idx1, pixel_on1, frame_idx1, busy1, anim_done1);
    end
    @(negedge vga_clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_hit();
    int xs[9]  = '{100, 149, 150, 108, 101, 103, 0, 0, 0};
    bit bl[9]  = '{1, 1, 1, 1, 0, 1, 0, 0, 0};
    int ea0[6] = '{0, 49, 49, 8, 1, 3};
    int ea1[6] = '{0, 24, 25, 4, 0, 1};
    pos_x = 10'd100; pos_y = 10'd200; flip = 0;
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(xs[i], (i < 6) ? 200 : 0, bl[i], 0, 0);
      if (i < 6) begin
        checks++;
        if (rom_address0 !== AW'(ea0[i]) || rom_address1 !== AW'(ea1[i])) begin
          errors++; $display("FAIL hit_addr x=%0d got %0d/%0d want %0d/%0d",
            xs[i], rom_address0, rom_address1, ea0[i], ea1[i]);
        end
      end
      if (due) begin
        checks++;
        if ({pixel_on0, pixel_idx0, pixel_on1, pixel_idx1} !== {exp_p0, exp_p1}) begin
          errors++; $display("FAIL hit_pix step=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d", i,
            pixel_on0, pixel_idx0, pixel_on1, pixel_idx1, exp_p0.on, exp_p0.idx, exp_p1.on, exp_p1.idx);
        end
      end
    end
  endtask

  task automatic test_flip();
    int xs[5]  = '{100, 103, 0, 0, 0};
    int ys[5]  = '{201, 200, 0, 0, 0};
    int ea0[2] = '{99, 46};
    int ea1[2] = '{49, 48};
    flip = 1;
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(xs[i], ys[i], i < 2, 0, 0);
      if (i < 2) begin
        checks++;
        if (rom_address0 !== AW'(ea0[i]) || rom_address1 !== AW'(ea1[i])) begin
          errors++; $display("FAIL flip_addr step=%0d got %0d/%0d want %0d/%0d",
            i, rom_address0, rom_address1, ea0[i], ea1[i]);
        end
      end
      if (due) begin
        checks++;
        if ({pixel_on0, pixel_idx0, pixel_on1, pixel_idx1} !== {exp_p0, exp_p1}) begin
          errors++; $display("FAIL flip_pix step=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d", i,
            pixel_on0, pixel_idx0, pixel_on1, pixel_idx1, exp_p0.on, exp_p0.idx, exp_p1.on, exp_p1.idx);
        end
      end
    end
  endtask

  task automatic test_anim();
    flip = 0;
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (busy0 !== 1'b1 || frame_idx0 !== 2'd0) begin
      errors++; $display("FAIL anim_start got busy=%b frame=%0d want 1/0", busy0, frame_idx0);
    end
    for (int t = 1; t <= 24; t++) begin
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (frame_idx0 !== 2'(m_fr) || busy0 !== (m_st == 1) || anim_done0 !== m_done) begin
        errors++; $display("FAIL anim_seq tick=%0d got f=%0d b=%b d=%b want f=%0d b=%b d=%b",
          t, frame_idx0, busy0, anim_done0, m_fr, m_st == 1, m_done);
      end
      if (t == 6) begin
        cycle(100, 200, 1, 0, 0);
        checks++;
        if (frame_idx0 !== 2'd1 || rom_address0 !== AW'(3200) || rom_address1 !== AW'(3200)) begin
          errors++; $display("FAIL anim_frame1 got f=%0d addr=%0d/%0d want 1/3200/3200",
            frame_idx0, rom_address0, rom_address1);
        end
      end
      if (t == 24) begin
        checks++;
`ifdef ANIM_LOOP_EN
        if (frame_idx0 !== 2'd0 || busy0 !== 1'b1 || anim_done0 !== 1'b0) begin
`else
        if (frame_idx0 !== 2'd3 || busy0 !== 1'b0 || anim_done0 !== 1'b1) begin
`endif
          errors++; $display("FAIL anim_end got f=%0d b=%b d=%b", frame_idx0, busy0, anim_done0);
        end
      end
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (anim_done0 !== 1'b0 || anim_done1 !== 1'b0 || frame_idx0 !== 2'(m_fr)) begin
      errors++; $display("FAIL anim_pulse got d=%b/%b f=%0d want 0/0/%0d",
        anim_done0, anim_done1, frame_idx0, m_fr);
    end
  endtask

  task automatic test_start_tick();
    cycle(0, 0, 0, 0, 1);
    for (int t = 0; t < 15; t++) cycle(0, 0, 0, 1, 0);
    checks++;
    if (frame_idx0 !== 2'd2 || busy0 !== 1'b1) begin
      errors++; $display("FAIL st_pre got f=%0d b=%b want 2/1", frame_idx0, busy0);
    end
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (frame_idx0 !== 2'd0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL st_restart got f=%0d b=%b want 0/1", frame_idx0, busy0);
    end
    for (int t = 1; t <= 6; t++) begin
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (frame_idx0 !== ((t == 6) ? 2'd1 : 2'd0) || frame_idx1 !== 2'(m_fr)) begin
        errors++; $display("FAIL st_hold tick=%0d got f=%0d/%0d want %0d",
          t, frame_idx0, frame_idx1, (t == 6) ? 1 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    pos_x = 10'd300; pos_y = 10'd100; flip = 1;
    cycle(0, 0, 0, 1, 0);
    for (int x = 295; x < 362; x++) begin
      if (x < 359) cycle(x, 110, 1, 0, 0);
      else cycle(0, 0, 0, 0, 0);
      checks++;
      if (rom_address0 !== AW'(exp_a0) || rom_address1 !== AW'(exp_a1)) begin
        errors++; $display("FAIL b2b_addr x=%0d got %0d/%0d want %0d/%0d",
          x, rom_address0, rom_address1, exp_a0, exp_a1);
      end
      if (due) begin
        checks++;
        if ({pixel_on0, pixel_idx0, pixel_on1, pixel_idx1} !== {exp_p0, exp_p1}) begin
          errors++; $display("FAIL b2b_pix x=%0d got %b/%0d %b/%0d want %b/%0d %b/%0d", x,
            pixel_on0, pixel_idx0, pixel_on1, pixel_idx1, exp_p0.on, exp_p0.idx, exp_p1.on, exp_p1.idx);
        end
      end
    end
  endtask

  task automatic test_reset_midplay();
    cycle(0, 0, 0, 0, 1);
    for (int t = 0; t < 12; t++) cycle(120, 210, 1, 1, 0);
    checks++;
    if (frame_idx0 !== 2'd2 || busy0 !== 1'b1) begin
      errors++; $display("FAIL rmp_pre got f=%0d b=%b want 2/1", frame_idx0, busy0);
    end
    frame_tick = 0; anim_start = 0;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({rom_address0, pixel_idx0, pixel_on0, frame_idx0, busy0, anim_done0,
         rom_address1, pixel_idx1, pixel_on1, frame_idx1, busy1, anim_done1} !== '0) begin
      errors++; $display("FAIL rmp_async got %h/%h/%b/%h/%b/%b want all 0",
        rom_address0, pixel_idx0, pixel_on0, frame_idx0, busy0, anim_done0);
    end
    @(negedge vga_clk);
    Reset = 1'b0;
    model_reset();
    for (int t = 0; t < 8; t++) begin
      cycle(0, 0, 0, t[0], 0);
      checks++;
      if (anim_done0 !== 1'b0 || busy0 !== 1'b0 || frame_idx0 !== 2'd0) begin
        errors++; $display("FAIL rmp_after t=%0d got d=%b b=%b f=%0d want 0/0/0",
          t, anim_done0, busy0, frame_idx0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_flip();
    test_anim();
    test_start_tick();
    test_back_to_back();
    test_reset_midplay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
